// File: rtl/nios_system_sysid_checker_pkg.sv
// Shared state encoding, sysid word addresses and counter width for the sysid checker.
package nios_system_sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned ERR_COUNT_W = 8;

  function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM master that reads sysid words 0/1 and registers a pass/fail verdict.
// Optional periodic re-check: define SYSID_CHECK_PERIODIC_EN.
module nios_system_sysid_checker
  import nios_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1480389732,
  parameter int unsigned TIMEOUT        = 16,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned CHECK_INTERVAL = 1000000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   avm_address,
  output logic                   avm_read,
  input  logic                   avm_waitrequest,
  input  logic [31:0]            avm_readdata,
  output logic                   busy,
  output logic                   done,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              auto_pend;
  logic              periodic_hit;
  logic              trigger;
  logic              reading;
  logic              wait_expired;

  always_comb begin
    reading      = (state == RD_ID) || (state == RD_TS);
    trigger      = (state == IDLE) && (start || auto_pend || periodic_hit);
    wait_expired = (TIMEOUT != 0) && reading && avm_waitrequest &&
                   (wait_cnt == WAIT_W'(TO_LAST));
    state_next   = state;
    case (state)
      IDLE:  if (trigger) state_next = RD_ID;
      RD_ID: if (!avm_waitrequest) state_next = RD_TS;
             else if (wait_expired) state_next = IDLE;
      RD_TS: if (!avm_waitrequest) state_next = CMP;
             else if (wait_expired) state_next = IDLE;
      CMP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    avm_read    = reading;
    avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy        = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Any state change restarts the stall count, so each read gets a fresh budget.
  always_ff @(posedge clock) begin
    if (!reset_n || (state_next != state)) wait_cnt <= '0;
    else if (reading && avm_waitrequest)   wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      auto_pend <= AUTO_START;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
      err_count <= '0;
    end else begin
      auto_pend <= 1'b0;
      done      <= 1'b0;
      case (state)
        RD_ID: if (!avm_waitrequest) id_value <= avm_readdata;
        RD_TS: if (!avm_waitrequest) ts_value <= avm_readdata;
        CMP: begin
          id_ok   <= (id_value == EXPECTED_ID);
          ts_ok   <= (ts_value == EXPECTED_TS);
          timeout <= 1'b0;
          done    <= 1'b1;
          if ((id_value != EXPECTED_ID) || (ts_value != EXPECTED_TS))
            err_count <= sat_inc(err_count);
        end
        default: ;
      endcase
      if (wait_expired) begin
        timeout   <= 1'b1;
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
        done      <= 1'b1;
        err_count <= sat_inc(err_count);
      end
    end
  end

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam int unsigned IV_LAST = (CHECK_INTERVAL == 0) ? 0 : CHECK_INTERVAL - 1;
  localparam int unsigned IV_W    = (CHECK_INTERVAL < 2) ? 1 : $clog2(CHECK_INTERVAL);

  logic [IV_W-1:0] iv_cnt;

  always_comb periodic_hit = (state == IDLE) && (iv_cnt == IV_W'(IV_LAST));

  always_ff @(posedge clock) begin
    if (!reset_n || (state != IDLE) || start || trigger) iv_cnt <= '0;
    else                                                 iv_cnt <= iv_cnt + 1'b1;
  end
`else
  // Interval setting has no effect without the periodic build.
  always_comb periodic_hit = (CHECK_INTERVAL == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Scoreboard bench for nios_system_sysid_checker with a behavioural sysid slave.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'h583C_F464;
  localparam int unsigned TO     = 16;
  localparam int unsigned IV     = 20;

  logic        clock, reset_n, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic [7:0]  err_count;

  logic [31:0] model_id, model_ts;
  assign avm_readdata = avm_address ? model_ts : model_id;

  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT(TO),
    .AUTO_START(1'b1),
    .CHECK_INTERVAL(IV)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .busy(busy),
    .done(done),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic        id_ok, ts_ok, tmo;
    logic [31:0] id_v, ts_v;
    logic [7:0]  err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          exp_err;
  logic [31:0] last_id, last_ts;

  // Reference model: a completed check latches the slave's words, an aborted one keeps the old.
  task automatic expect_done(input int unsigned when, input bit tmo);
    exp_t e;
    if (!tmo) begin
      last_id = model_id;
      last_ts = model_ts;
    end
    e.cyc   = when;
    e.tmo   = tmo;
    e.id_ok = !tmo && (last_id == EXP_ID);
    e.ts_ok = !tmo && (last_ts == EXP_TS);
    if (!(e.id_ok && e.ts_ok) && exp_err < 255) exp_err++;
    e.err  = 8'(exp_err);
    e.id_v = last_id;
    e.ts_v = last_ts;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("id_ok", id_ok, mon_e.id_ok);
        check("ts_ok", ts_ok, mon_e.ts_ok);
        check("timeout", timeout, mon_e.tmo);
        check("id_value", id_value, mon_e.id_v);
        check("ts_value", ts_value, mon_e.ts_v);
        check("err_count", err_count, mon_e.err);
        check("busy_at_done", busy, 32'd0);
        check("read_at_done", avm_read, 32'd0);
      end
    end
  end

  task automatic drain(input int unsigned limit);
    int unsigned n = 0;
    while ((sb.size() != 0) && (n < limit)) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_bound", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // a/b: stalled cycles on the ID/TS reads; stuck: waitrequest never drops.
  task automatic run_check(input int unsigned a, input int unsigned b, input bit stuck);
    @(negedge clock);
    start           = 1'b1;
    avm_waitrequest = 1'b0;
    expect_done(stuck ? cyc + 1 + TO : cyc + 4 + a + b, stuck);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 32'd1);
    check("read_after_start", avm_read, 32'd1);
    check("addr_id", avm_address, 32'd0);
    if (stuck) begin
      avm_waitrequest = 1'b1;
      repeat (TO) @(posedge clock);
      #1;
      check("read_dropped", avm_read, 32'd0);
    end else begin
      for (int unsigned k = 1; k <= a + b + 2; k++) begin
        avm_waitrequest = (k <= a) || ((k >= a + 2) && (k <= a + 1 + b));
        if ((k >= a + 2) && (k <= a + 1 + b)) check("addr_ts_hold", avm_address, 32'd1);
        @(posedge clock);
        #1;
      end
    end
    avm_waitrequest = 1'b0;
    drain(50);
  endtask

  initial begin
    int unsigned nd;
    reset_n = 1'b0;
    start = 1'b0;
    avm_waitrequest = 1'b0;
    model_id = EXP_ID;
    model_ts = EXP_TS;
    exp_err = 0;
    last_id = '0;
    last_ts = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_read", avm_read, 32'd0);
    check("rst_id_ok", id_ok, 32'd0);
    check("rst_ts_ok", ts_ok, 32'd0);
    check("rst_timeout", timeout, 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);
    check("rst_err", err_count, 32'd0);

    reset_n = 1'b1;
    nd = cyc + 4;
    expect_done(nd, 1'b0);
    @(posedge clock);
    #1;
    check("auto_busy", busy, 32'd1);
    drain(50);

`ifdef SYSID_CHECK_PERIODIC_EN
    model_ts = 32'h0000_0001;
    for (int i = 0; i < 258; i++) begin
      nd = nd + IV + 3;
      expect_done(nd, 1'b0);
      drain(IV + 20);
    end
    check("periodic_err_sat", err_count, 32'd255);
`else
    model_ts = 32'h0000_0001;
    run_check(0, 0, 1'b0);
    model_ts = EXP_TS;
    run_check(3, 0, 1'b0);
    run_check(0, 2, 1'b0);
    run_check(0, 0, 1'b1);
    model_id = 32'hDEAD_BEEF;
    run_check(1, 1, 1'b0);
    model_id = EXP_ID;

    // start held across the whole check must not queue a second one
    @(negedge clock);
    start = 1'b1;
    expect_done(cyc + 4, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b0;
    drain(50);
    repeat (8) @(negedge clock);
    check("no_extra_check", busy, 32'd0);

    // reset while reading the timestamp
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    check("in_rd_ts", avm_address, 32'd1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("mid_rst_read", avm_read, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_done", done, 32'd0);
    check("mid_rst_err", err_count, 32'd0);
    check("mid_rst_id", id_value, 32'd0);
    check("mid_rst_id_ok", id_ok, 32'd0);
    exp_err = 0;
    last_id = '0;
    last_ts = '0;
    @(negedge clock);
    reset_n = 1'b1;
    expect_done(cyc + 4, 1'b0);
    drain(50);

    model_ts = 32'h0000_0001;
    for (int i = 0; i < 260; i++) run_check(0, 0, 1'b0);
    check("err_saturated", err_count, 32'd255);
`endif

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nios_system_sysid_checker.md
# nios_system_sysid_checker

Avalon-MM master that sequences reads of the system ID peripheral (word 0 = system ID, word 1 = build timestamp) and compares both against expected values. It sits beside the Nios II master on the system interconnect. It gives boot and debug logic a registered pass/fail verdict without processor involvement. A check runs automatically after reset and on request; an optional periodic re-check is compiled in by macro.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, value required at sysid address 0
- EXPECTED_TS, 32'd1480389732 (32'h583C_F464), value required at sysid address 1
- TIMEOUT, 16, max cycles waitrequest may stay high per access; 0 disables the timeout
- AUTO_START, 1, start a check on the first clock edge after reset deasserts
- CHECK_INTERVAL, 1000000, idle cycles between periodic checks; used only with the macro

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request a check; sampled only in IDLE
- avm_address  out  1  sysid word select
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for the zero-wait sysid slave
- avm_readdata  in  32  read data, valid in any cycle with avm_read=1 and avm_waitrequest=0
- busy  out  1  check in progress
- done  out  1  one-cycle pulse on completion
- id_ok  out  1  last captured ID equals EXPECTED_ID
- ts_ok  out  1  last captured timestamp equals EXPECTED_TS
- timeout  out  1  last check aborted on waitrequest timeout
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp
- err_count  out  8  failed checks, saturating at 255

## Operation
- States: IDLE, RD_ID, RD_TS, CMP.
- IDLE: avm_read=0. On start=1 (or auto/periodic trigger), go to RD_ID and set busy.
- RD_ID: avm_read=1, avm_address=0. On avm_waitrequest=0, capture avm_readdata into id_value and go to RD_TS.
- RD_TS: avm_read=1, avm_address=1. On avm_waitrequest=0, capture ts_value and go to CMP.
- CMP: register id_ok and ts_ok, set timeout=0, pulse done, clear busy, return to IDLE. If either flag is 0, err_count increments.
- Wait counter:
  - Clears on entry to each read state; increments each cycle with waitrequest=1.
  - When it reaches TIMEOUT (if TIMEOUT≠0): deassert read, set timeout=1, id_ok=0, ts_ok=0, err_count+1 (saturating), pulse done, clear busy, go to IDLE.
  - id_value and ts_value keep the last successfully captured data.
- start while busy is ignored, not queued.
- Reset values: all outputs 0; state IDLE; counters 0.
- A reset mid-check aborts the check; avm_read is 0 on the edge after reset is sampled low.
- AUTO_START=1: the first edge with reset_n=1 behaves as start.

## Timing
- start sampled high at edge E0 → busy=1 and avm_read=1 after E0.
- Zero wait states: ID captured at E1, timestamp at E2, flags plus done=1 at E3.
- done is high for exactly one cycle, E3–E4; busy falls at E3.
- Each waitrequest cycle adds one cycle to the corresponding read.
- avm_address and avm_read change only on clock edges and are held stable while waitrequest=1.
- Timeout: done asserts on the edge where the wait count equals TIMEOUT, i.e. TIMEOUT stalled cycles after read assertion.
- err_count at 255 stays 255.

## Configuration
- SYSID_CHECK_PERIODIC_EN defined:
  - An interval counter counts cycles in IDLE.
  - On reaching CHECK_INTERVAL-1, it triggers a check and clears.
  - It also clears on start and while busy.
- SYSID_CHECK_PERIODIC_EN undefined: no interval counter; checks run only on start and AUTO_START.

## Structure
- Package nios_system_sysid_checker_pkg holds:
  - the state enum
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1
  - ERR_COUNT_W=8
- No sub-module; one module with a state register, a wait counter, and the optional interval counter.

## Test plan
- Reset release, AUTO_START=1, sysid model returns 0 and 1480389732 with zero wait → done at the third edge after reset release; id_ok=1, ts_ok=1, err_count=0.
- Model returns timestamp 32'h0000_0001, start pulse → ts_ok=0, id_ok=1, err_count=1, ts_value=1.
- waitrequest high for 3 cycles on RD_ID, TIMEOUT=16 → done 3 cycles later than the zero-wait case; reads pass.
- waitrequest stuck high, TIMEOUT=16 → done after 16 stall cycles; timeout=1, id_ok=0, avm_read=0 the next cycle.
- start held high through a check, plus reset_n low during RD_TS → no extra check while busy; after reset, outputs 0 and a new check completes cleanly.
- With SYSID_CHECK_PERIODIC_EN, CHECK_INTERVAL=20, forced mismatches → one check every 20 idle cycles; err_count saturates at 255 after 255+ checks.
